// File: rtl/wb_statis_pkg.sv
// Shared definitions for the white-balance statistics block and the wb gain stage.
//   wb_state_e  : statistics FSM state encoding
//   MONO8_KEY   : {fmt[20], fmt[19], fmt[3:0]} value identifying Mono8
//   MONO10_KEY  : {fmt[20], fmt[19], fmt[3:0]} value identifying Mono10
//   is_mono_key : true when a format key selects a monochrome format
package wb_statis_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_ACCUM = 3'd2,
      S_FLUSH = 3'd3,
      S_LATCH = 3'd4
   } wb_state_e;

   localparam logic [5:0] MONO8_KEY  = 6'b010001;
   localparam logic [5:0] MONO10_KEY = 6'b100011;

   function automatic logic is_mono_key(input logic [5:0] key);
      return (key == MONO8_KEY) || (key == MONO10_KEY);
   endfunction

endpackage

// File: rtl/wb_statis_acc.sv
// Saturating per-channel accumulator: pixel sum plus pixel count.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : add pix to the sum and bump the count
//   pix          : pixel value to add
//   sum, num     : running sum and count, both clamp at all-ones
module wb_statis_acc #(
   parameter int DAT_W = 10,
   parameter int SUM_W = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DAT_W-1:0] pix,
   output logic [SUM_W-1:0] sum,
   output logic [CNT_W-1:0] num
);

   logic [SUM_W:0] sum_ext;
   logic [CNT_W:0] num_ext;

   // One extra bit catches the carry-out that triggers the clamp.
   assign sum_ext = {1'b0, sum} + {{(SUM_W + 1 - DAT_W){1'b0}}, pix};
   assign num_ext = {1'b0, num} + {{CNT_W{1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sum <= '0;
         num <= '0;
      end else if (clr) begin
         sum <= '0;
         num <= '0;
      end else if (en) begin
         sum <= sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
         num <= num_ext[CNT_W] ? {CNT_W{1'b1}} : num_ext[CNT_W-1:0];
      end
   end

endmodule

// File: rtl/wb_statis.sv
// Auto-white-balance statistics collector. Sums R, G and B Bayer pixels and
// counts them inside a programmable ROI, latching the per-frame results.
//   clk, reset_n            : pixel clock, asynchronous active-low reset
//   i_fval, i_lval          : frame / line valid; pixel valid when both high
//   iv_pix_data             : raw pixel
//   i_r/g/b_flag            : Bayer colour flags (R over G over B)
//   iv_pixel_format         : pixel format; Mono8/Mono10 disable statistics
//   iv_wb_offset_x/y        : ROI top-left corner
//   iv_wb_width/height      : ROI size (0 selects nothing)
//   ov_wb_statis_r/g/b      : latched channel sums
//   ov_wb_num_r/g/b         : latched channel pixel counts
//   o_wb_statis_done        : one-cycle pulse when the outputs update
//
// state   | meaning
// S_IDLE  | after reset, wait for i_fval low so a partial frame is dropped
// S_WAIT  | accumulators cleared, wait for i_fval rising edge
// S_ACCUM | frame in progress, pixels feed the pipeline
// S_FLUSH | two cycles draining the two-stage pipeline
// S_LATCH | publish results (non-mono frames) and pulse done
module wb_statis
   import wb_statis_pkg::*;
#(
   parameter int SENSOR_DAT_WIDTH = 10,
   parameter int STAT_WIDTH       = 32,
   parameter int REG_WD           = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        i_fval,
   input  logic                        i_lval,
   input  logic [SENSOR_DAT_WIDTH-1:0] iv_pix_data,
   input  logic                        i_r_flag,
   input  logic                        i_g_flag,
   input  logic                        i_b_flag,
   input  logic [REG_WD-1:0]           iv_pixel_format,
   input  logic [REG_WD-1:0]           iv_wb_offset_x,
   input  logic [REG_WD-1:0]           iv_wb_offset_y,
   input  logic [REG_WD-1:0]           iv_wb_width,
   input  logic [REG_WD-1:0]           iv_wb_height,
   output logic [STAT_WIDTH-1:0]       ov_wb_statis_r,
   output logic [STAT_WIDTH-1:0]       ov_wb_statis_g,
   output logic [STAT_WIDTH-1:0]       ov_wb_statis_b,
   output logic [REG_WD-1:0]           ov_wb_num_r,
   output logic [REG_WD-1:0]           ov_wb_num_g,
   output logic [REG_WD-1:0]           ov_wb_num_b,
   output logic                        o_wb_statis_done
);

   localparam logic [REG_WD-1:0] ONE = {{(REG_WD-1){1'b0}}, 1'b1};

   wb_state_e                   state;
   logic                        flush_cnt;
   logic                        frame_mono;
   logic                        fval_d, lval_d;
   logic                        fval_rise, lval_fall;
   logic                        mono_det, mono_sh;
   logic [REG_WD-1:0]           roi_x, roi_y, roi_w, roi_h;
   logic [REG_WD-1:0]           x_cnt, y_cnt;
   logic [REG_WD:0]             x_end, y_end;
   logic                        in_roi, accept;
   logic                        s1_vld;
   logic [2:0]                  s1_sel;
   logic [SENSOR_DAT_WIDTH-1:0] s1_pix;
   logic                        acc_clr;
   logic [STAT_WIDTH-1:0]       acc_sum_r, acc_sum_g, acc_sum_b;
   logic [REG_WD-1:0]           acc_num_r, acc_num_g, acc_num_b;
   logic                        fmt_unused;

   assign fmt_unused = ^{iv_pixel_format[REG_WD-1:21], iv_pixel_format[18:4]};

   assign fval_rise = i_fval & ~fval_d;
   assign lval_fall = lval_d & ~i_lval;

   // End bounds carry one extra bit so offset+size can never wrap.
   assign x_end  = {1'b0, roi_x} + {1'b0, roi_w};
   assign y_end  = {1'b0, roi_y} + {1'b0, roi_h};
   assign in_roi = (x_cnt >= roi_x) && ({1'b0, x_cnt} < x_end) &&
                   (y_cnt >= roi_y) && ({1'b0, y_cnt} < y_end);

   // The rising-edge cycle already carries a valid pixel if lval is high.
   assign accept = (state == S_ACCUM) || ((state == S_WAIT) && fval_rise);

   // Frozen ROI/mono copies so register writes mid-frame take effect next frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fval_d   <= 1'b0;
         lval_d   <= 1'b0;
         mono_det <= 1'b0;
         mono_sh  <= 1'b0;
         roi_x    <= '0;
         roi_y    <= '0;
         roi_w    <= '0;
         roi_h    <= '0;
      end else begin
         fval_d   <= i_fval;
         lval_d   <= i_lval;
         mono_det <= is_mono_key({iv_pixel_format[20], iv_pixel_format[19],
                                  iv_pixel_format[3:0]});
         if (!i_fval) begin
            mono_sh <= mono_det;
            roi_x   <= iv_wb_offset_x;
            roi_y   <= iv_wb_offset_y;
            roi_w   <= iv_wb_width;
            roi_h   <= iv_wb_height;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         x_cnt <= i_lval ? (x_cnt + ONE) : '0;
         if (state == S_WAIT)
            y_cnt <= '0;
         else if (i_fval && lval_fall)
            y_cnt <= y_cnt + ONE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_vld <= 1'b0;
         s1_sel <= '0;
         s1_pix <= '0;
      end else begin
         s1_vld <= accept && in_roi && i_fval && i_lval && !mono_sh;
         s1_pix <= iv_pix_data;
         s1_sel <= i_r_flag ? 3'b001 :
                   i_g_flag ? 3'b010 :
                   i_b_flag ? 3'b100 : 3'b000;
      end
   end

   assign acc_clr = (state == S_WAIT);

   wb_statis_acc #(.DAT_W(SENSOR_DAT_WIDTH), .SUM_W(STAT_WIDTH), .CNT_W(REG_WD)) u_acc_r (
      .clk(clk), .reset_n(reset_n), .clr(acc_clr), .en(s1_vld & s1_sel[0]),
      .pix(s1_pix), .sum(acc_sum_r), .num(acc_num_r));

   wb_statis_acc #(.DAT_W(SENSOR_DAT_WIDTH), .SUM_W(STAT_WIDTH), .CNT_W(REG_WD)) u_acc_g (
      .clk(clk), .reset_n(reset_n), .clr(acc_clr), .en(s1_vld & s1_sel[1]),
      .pix(s1_pix), .sum(acc_sum_g), .num(acc_num_g));

   wb_statis_acc #(.DAT_W(SENSOR_DAT_WIDTH), .SUM_W(STAT_WIDTH), .CNT_W(REG_WD)) u_acc_b (
      .clk(clk), .reset_n(reset_n), .clr(acc_clr), .en(s1_vld & s1_sel[2]),
      .pix(s1_pix), .sum(acc_sum_b), .num(acc_num_b));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state            <= S_IDLE;
         flush_cnt        <= 1'b0;
         frame_mono       <= 1'b0;
         ov_wb_statis_r   <= '0;
         ov_wb_statis_g   <= '0;
         ov_wb_statis_b   <= '0;
         ov_wb_num_r      <= '0;
         ov_wb_num_g      <= '0;
         ov_wb_num_b      <= '0;
         o_wb_statis_done <= 1'b0;
      end else begin
         o_wb_statis_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!i_fval) state <= S_WAIT;
            end
            S_WAIT: begin
               if (fval_rise) begin
                  frame_mono <= mono_sh;
                  state      <= S_ACCUM;
               end
            end
            S_ACCUM: begin
               flush_cnt <= 1'b0;
               if (!i_fval) state <= S_FLUSH;
            end
            S_FLUSH: begin
               flush_cnt <= 1'b1;
               if (flush_cnt) state <= S_LATCH;
            end
            S_LATCH: begin
               if (!frame_mono) begin
                  ov_wb_statis_r   <= acc_sum_r;
                  ov_wb_statis_g   <= acc_sum_g;
                  ov_wb_statis_b   <= acc_sum_b;
                  ov_wb_num_r      <= acc_num_r;
                  ov_wb_num_g      <= acc_num_g;
                  ov_wb_num_b      <= acc_num_b;
                  o_wb_statis_done <= 1'b1;
               end
               state <= S_WAIT;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_statis.sv
module tb_wb_statis;

   localparam int SDW = 10;
   localparam int SW  = 12;
   localparam int RW  = 32;
   localparam longint SUM_MAX = (64'd1 << SW) - 1;

   localparam logic [RW-1:0] FMT_RG10   = 32'h010C_000D;
   localparam logic [RW-1:0] FMT_MONO10 = 32'h0110_0003;
   localparam logic [RW-1:0] FMT_MONO8  = 32'h0108_0001;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           i_fval, i_lval;
   logic [SDW-1:0] iv_pix_data;
   logic           i_r_flag, i_g_flag, i_b_flag;
   logic [RW-1:0]  iv_pixel_format;
   logic [RW-1:0]  iv_wb_offset_x, iv_wb_offset_y, iv_wb_width, iv_wb_height;
   logic [SW-1:0]  ov_wb_statis_r, ov_wb_statis_g, ov_wb_statis_b;
   logic [RW-1:0]  ov_wb_num_r, ov_wb_num_g, ov_wb_num_b;
   logic           o_wb_statis_done;

   int     n_chk = 0;
   int     n_bad = 0;
   int     done_cnt = 0;
   longint exp_sum[3];
   longint exp_num[3];

   wb_statis #(.SENSOR_DAT_WIDTH(SDW), .STAT_WIDTH(SW), .REG_WD(RW)) dut (
      .clk(clk), .reset_n(reset_n), .i_fval(i_fval), .i_lval(i_lval),
      .iv_pix_data(iv_pix_data), .i_r_flag(i_r_flag), .i_g_flag(i_g_flag),
      .i_b_flag(i_b_flag), .iv_pixel_format(iv_pixel_format),
      .iv_wb_offset_x(iv_wb_offset_x), .iv_wb_offset_y(iv_wb_offset_y),
      .iv_wb_width(iv_wb_width), .iv_wb_height(iv_wb_height),
      .ov_wb_statis_r(ov_wb_statis_r), .ov_wb_statis_g(ov_wb_statis_g),
      .ov_wb_statis_b(ov_wb_statis_b), .ov_wb_num_r(ov_wb_num_r),
      .ov_wb_num_g(ov_wb_num_g), .ov_wb_num_b(ov_wb_num_b),
      .o_wb_statis_done(o_wb_statis_done));

   always #5 clk = ~clk;

   always @(negedge clk) if (o_wb_statis_done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_outputs(input string tag);
      chk({tag, "_sum_r"}, 64'(ov_wb_statis_r), exp_sum[0]);
      chk({tag, "_sum_g"}, 64'(ov_wb_statis_g), exp_sum[1]);
      chk({tag, "_sum_b"}, 64'(ov_wb_statis_b), exp_sum[2]);
      chk({tag, "_num_r"}, 64'(ov_wb_num_r), exp_num[0]);
      chk({tag, "_num_g"}, 64'(ov_wb_num_g), exp_num[1]);
      chk({tag, "_num_b"}, 64'(ov_wb_num_b), exp_num[2]);
   endtask

   task automatic set_roi(input logic [RW-1:0] x, input logic [RW-1:0] y,
                          input logic [RW-1:0] w, input logic [RW-1:0] h);
      iv_wb_offset_x = x;
      iv_wb_offset_y = y;
      iv_wb_width    = w;
      iv_wb_height   = h;
   endtask

   // mode 0: constant 100 RGGB, 1: ramp x+8y RGGB, 2: all-R 1023, 3: random pixel and flags
   task automatic run_frame(input string tag, input int w, input int h, input int mode,
                            input int chg_row, input int rst_row);
      int     d0;
      longint rx, ry, rwd, rht;
      longint s[3];
      longint n[3];
      bit     mono, aborted;
      logic [5:0] key;
      logic [2:0] fl;
      logic [SDW-1:0] p;
      int     ch;

      aborted = 0;
      repeat (6) @(negedge clk);
      d0  = done_cnt;
      rx  = longint'(iv_wb_offset_x);
      ry  = longint'(iv_wb_offset_y);
      rwd = longint'(iv_wb_width);
      rht = longint'(iv_wb_height);
      key  = {iv_pixel_format[20], iv_pixel_format[19], iv_pixel_format[3:0]};
      mono = (key == 6'b010001) || (key == 6'b100011);
      for (int c = 0; c < 3; c++) begin s[c] = 0; n[c] = 0; end

      i_fval = 1'b1;
      repeat (2) @(negedge clk);
      for (int yy = 0; yy < h; yy++) begin
         if (yy == chg_row)
            set_roi($urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(1, 5), $urandom_range(1, 3));
         if (yy == rst_row) begin
            reset_n = 1'b0;
            @(negedge clk);
            chk({tag, "_rst_sum_g"}, 64'(ov_wb_statis_g), 0);
            chk({tag, "_rst_num_r"}, 64'(ov_wb_num_r), 0);
            chk({tag, "_rst_done"}, 64'(o_wb_statis_done), 0);
            @(negedge clk);
            reset_n = 1'b1;
            aborted = 1;
         end
         for (int xx = 0; xx < w; xx++) begin
            case (mode)
               0: p = SDW'(100);
               1: p = SDW'(xx + 8 * yy);
               2: p = SDW'(1023);
               default: p = SDW'($urandom_range(0, 1023));
            endcase
            if (mode == 2)
               fl = 3'b001;
            else if (mode == 3)
               fl = 3'($urandom_range(0, 7));
            else if ((yy % 2 == 0) && (xx % 2 == 0))
               fl = 3'b001;
            else if ((yy % 2 == 1) && (xx % 2 == 1))
               fl = 3'b100;
            else
               fl = 3'b010;
            i_lval      = 1'b1;
            iv_pix_data = p;
            i_r_flag    = fl[0];
            i_g_flag    = fl[1];
            i_b_flag    = fl[2];
            ch = fl[0] ? 0 : fl[1] ? 1 : fl[2] ? 2 : -1;
            if (!mono && ch >= 0 && xx >= rx && xx < rx + rwd && yy >= ry && yy < ry + rht) begin
               s[ch] = s[ch] + longint'(p);
               if (s[ch] > SUM_MAX) s[ch] = SUM_MAX;
               n[ch] = n[ch] + 1;
            end
            @(negedge clk);
         end
         i_lval = 1'b0;
         i_r_flag = 1'b0; i_g_flag = 1'b0; i_b_flag = 1'b0;
         iv_pix_data = '0;
         repeat (2) @(negedge clk);
      end
      i_fval = 1'b0;
      repeat (10) @(negedge clk);

      if (aborted) begin
         for (int c = 0; c < 3; c++) begin exp_sum[c] = 0; exp_num[c] = 0; end
         chk({tag, "_done_count"}, 64'(done_cnt - d0), 0);
      end else if (mono) begin
         chk({tag, "_done_count"}, 64'(done_cnt - d0), 0);
      end else begin
         for (int c = 0; c < 3; c++) begin exp_sum[c] = s[c]; exp_num[c] = n[c]; end
         chk({tag, "_done_count"}, 64'(done_cnt - d0), 1);
      end
      chk_outputs(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      i_fval = 1'b0; i_lval = 1'b0; iv_pix_data = '0;
      i_r_flag = 1'b0; i_g_flag = 1'b0; i_b_flag = 1'b0;
      iv_pixel_format = FMT_RG10;
      set_roi(0, 0, 8, 4);
      for (int c = 0; c < 3; c++) begin exp_sum[c] = 0; exp_num[c] = 0; end
      repeat (3) @(negedge clk);
      chk("reset_done", 64'(o_wb_statis_done), 0);
      chk_outputs("reset");
      reset_n = 1'b1;

      run_frame("const", 8, 4, 0, -1, -1);
      chk("const_sum_r_abs", 64'(ov_wb_statis_r), 800);
      chk("const_sum_g_abs", 64'(ov_wb_statis_g), 1600);
      chk("const_num_g_abs", 64'(ov_wb_num_g), 16);

      set_roi(2, 1, 4, 2);
      run_frame("ramp", 8, 4, 1, -1, -1);
      chk("ramp_num_g_abs", 64'(ov_wb_num_g), 4);

      set_roi(0, 0, 8, 8);
      run_frame("sat", 8, 8, 2, -1, -1);
      chk("sat_sum_r_abs", 64'(ov_wb_statis_r), 4095);
      chk("sat_num_r_abs", 64'(ov_wb_num_r), 64);

      iv_pixel_format = FMT_MONO10;
      run_frame("mono10", 8, 4, 3, -1, -1);
      iv_pixel_format = FMT_MONO8;
      run_frame("mono8", 6, 3, 0, -1, -1);
      iv_pixel_format = FMT_RG10;

      set_roi(0, 0, 8, 4);
      run_frame("roi_mid", 8, 4, 3, 1, -1);
      run_frame("roi_next", 8, 4, 3, -1, -1);

      set_roi(1, 0, 6, 4);
      run_frame("rst_mid", 8, 4, 0, -1, 2);
      run_frame("after_rst", 8, 4, 0, -1, -1);

      set_roi(32'hFFFF_FFF0, 0, 32'h20, 4);
      run_frame("roi_wrap", 8, 4, 0, -1, -1);
      set_roi(0, 0, 0, 4);
      run_frame("roi_w0", 8, 4, 0, -1, -1);

      for (int k = 0; k < 6; k++) begin
         set_roi($urandom_range(0, 6), $urandom_range(0, 3),
                 $urandom_range(0, 12), $urandom_range(0, 5));
         run_frame($sformatf("rand%0d", k), $urandom_range(2, 12), $urandom_range(1, 5),
                   3, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
